// File: rtl/rom_loader_pkg.sv
// Shared widths and loader state encodings; the fetch-side ROM uses the same WORD_W/ADDR_W.
package rom_loader_pkg;
  localparam int WORD_W   = 37;
  localparam int ADDR_W   = 8;
  localparam int BYTES_PW = 5;
  // Number of meaningful bits in the last byte of a word; the rest must be zero.
  localparam int TOP_BITS = WORD_W - 8 * (BYTES_PW - 1);
  localparam int IDX_W    = $clog2(BYTES_PW);

  typedef enum logic [2:0] {
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;
endpackage

// File: rtl/rom_loader_if.sv
// Byte stream in, instruction RAM write port out, plus loader status.
interface rom_loader_if;
  logic                              start;
  logic [7:0]                        in_data;
  logic                              in_valid;
  logic                              in_ready;
  logic                              mem_we;
  logic [rom_loader_pkg::ADDR_W-1:0] mem_addr;
  logic [rom_loader_pkg::WORD_W-1:0] mem_din;
  logic                              cpu_hold;
  logic                              done;
  logic                              err;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_din, cpu_hold, done, err
  );
  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_din, cpu_hold, done, err
  );
endinterface

// File: rtl/rom_loader_word_packer.sv
// Assembles BYTES_PW little-endian bytes into one word; word_ready flags the final byte.
module word_packer
  import rom_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [7:0]        din,
    output logic              word_ready,
    output logic [WORD_W-1:0] word
);
    logic [IDX_W-1:0]            idx;
    logic [8*(BYTES_PW-1)-1:0]   sh;

    // The last byte is used straight off the input so the write can be registered on the same edge.
    assign word_ready = push && (idx == IDX_W'(BYTES_PW - 1));
    assign word       = {din[TOP_BITS-1:0], sh};

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            idx <= '0;
            sh  <= '0;
        end else if (push) begin
            sh  <= {din, sh[8*(BYTES_PW-1)-1:8]};
            idx <= word_ready ? '0 : idx + IDX_W'(1);
        end
    end
endmodule

// File: rtl/rom_loader.sv
// Run-time instruction RAM loader: [N][N*5 bytes][chk] frame -> one write per word, CPU held until done.
// Optional checksum byte enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader
  import rom_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    rom_loader_if.slave  bus
);
    state_t              state;
    logic                in_ready, mem_we, cpu_hold, done, err;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_din;
    logic [8:0]          remaining;
    logic                xfer, word_ready;
    logic [WORD_W-1:0]   word;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]          chk;
`endif

    assign xfer = bus.in_valid && in_ready;

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state == ST_COUNT),
        .push       (xfer && state == ST_DATA),
        .din        (bus.in_data),
        .word_ready (word_ready),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_COUNT;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            remaining <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            chk       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
            case (state)
                ST_COUNT: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        remaining <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                        mem_addr  <= '0;
                        state     <= ST_DATA;
`ifdef ROM_LOADER_CHECKSUM_EN
                        chk       <= '0;
`endif
                    end
                end
                ST_DATA: if (xfer) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                    chk <= chk ^ bus.in_data;
`endif
                    if (word_ready) begin
                        if (|bus.in_data[7:TOP_BITS]) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_din   <= word;
                            remaining <= remaining - 9'd1;
                            if (remaining == 9'd1) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                                state    <= ST_CHECK;
`else
                                state    <= ST_DONE;
                                in_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                ST_CHECK: if (xfer) begin
                    in_ready <= 1'b0;
                    state    <= (bus.in_data == chk) ? ST_DONE : ST_ERR;
                end
`endif
                ST_DONE: begin
                    // Status is set one cycle after entry so done trails the final write.
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                    in_ready <= 1'b0;
                    if (bus.start) begin
                        state    <= ST_COUNT;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
                        mem_addr <= '0;
                        in_ready <= 1'b1;
                    end
                end
                ST_ERR: begin
                    err      <= 1'b1;
                    cpu_hold <= 1'b1;
                    in_ready <= 1'b0;
                    if (bus.start) begin
                        state    <= ST_COUNT;
                        err      <= 1'b0;
                        mem_addr <= '0;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= ST_COUNT;
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.mem_we   = mem_we;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_din  = mem_din;
    assign bus.cpu_hold = cpu_hold;
    assign bus.done     = done;
    assign bus.err      = err;
endmodule
